l2_request_arbiter: RTL and testbench

- Shares one L2/memory port between the two L1 cache snooper interfaces (L1a = port 0, L1b = port 1).
- Queues each L1's eviction writes and line-fill reads, and issues at most one memory operation per cycle under round-robin.
- Tracks outstanding reads and routes the in-order memory responses back to the requesting L1.
- Replaces the per-L1 private memory instances in the testbench.

---
 rtl/l2_arb_pkg.sv | 28 ++
 rtl/l2_request_arbiter_if.sv | 49 ++++
 rtl/l2_request_arbiter_sync_fifo.sv | 73 +++++++
 rtl/l2_request_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_l2_request_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_arb_pkg.sv
// ---------------------------------------------------------------------------
// l2_arb_pkg
// Shared types and widths for the two-port L2 request arbiter.
//   port_id_t   : which L1 a request/response belongs to (A = 0, B = 1)
//   req_entry_t : one request-queue entry {rd, wr, addr, wdata}
// ---------------------------------------------------------------------------
package l2_arb_pkg;

  localparam int ADDR_W    = 32;
  localparam int LINE_W    = 128;
  localparam int NUM_PORTS = 2;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } req_entry_t;

  // 1 + 1 + 32 + 128 = 162
  localparam int REQ_W = $bits(req_entry_t);

endpackage

// File: rtl/l2_request_arbiter_if.sv
// ---------------------------------------------------------------------------
// l2_request_arbiter_if
// Bus bundle between the two L1 snoopers, the arbiter and the shared memory.
//   l1_*_a / l1_*_b : request side of L1a / L1b plus their fill return path
//   mem_*           : the single shared memory port
// Modports:
//   slave  : the arbiter's view (serves the L1s, drives the memory port)
//   master : the environment's view (L1s and memory model)
// ---------------------------------------------------------------------------
interface l2_request_arbiter_if;
  import l2_arb_pkg::*;

  logic [ADDR_W-1:0] l1_addr_a;
  logic [ADDR_W-1:0] l1_addr_b;
  logic              l1_rden_a;
  logic              l1_rden_b;
  logic              l1_wren_a;
  logic              l1_wren_b;
  logic [LINE_W-1:0] l1_wdata_a;
  logic [LINE_W-1:0] l1_wdata_b;
  logic [LINE_W-1:0] l1_rdata_a;
  logic [LINE_W-1:0] l1_rdata_b;
  logic              l1_rvalid_a;
  logic              l1_rvalid_b;

  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_rden;
  logic              mem_wren;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport slave (
    input  l1_addr_a, l1_addr_b, l1_rden_a, l1_rden_b,
           l1_wren_a, l1_wren_b, l1_wdata_a, l1_wdata_b,
           mem_rdata, mem_rvalid,
    output l1_rdata_a, l1_rdata_b, l1_rvalid_a, l1_rvalid_b,
           mem_addr, mem_wdata, mem_rden, mem_wren
  );

  modport master (
    output l1_addr_a, l1_addr_b, l1_rden_a, l1_rden_b,
           l1_wren_a, l1_wren_b, l1_wdata_a, l1_wdata_b,
           mem_rdata, mem_rvalid,
    input  l1_rdata_a, l1_rdata_b, l1_rvalid_a, l1_rvalid_b,
           mem_addr, mem_wdata, mem_rden, mem_wren
  );

endinterface

// File: rtl/l2_request_arbiter_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a combinational head (data_o shows the oldest entry
// whenever empty_o is low).
//   clk, reset      : clock, synchronous active-high reset (empties the FIFO)
//   push_i, data_i  : write request; ignored while full
//   pop_i           : remove head; ignored while empty
//   data_o          : current head entry
//   full_o, empty_o : occupancy flags
// Push and pop in the same cycle are both honoured. A push that arrives
// while full is dropped even if a pop happens in that cycle, so the caller
// can flag the drop from full_o alone.
// DEPTH must be a power of two (pointers wrap naturally).
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/l2_request_arbiter.sv
// ---------------------------------------------------------------------------
// l2_request_arbiter
// Shares one memory port between two L1 caches (A = port 0, B = port 1).
// Each L1's eviction writes and line-fill reads are queued per port; at most
// one memory operation issues per cycle, round-robin between ports. Read
// tags (the requesting port id) are queued in issue order so the in-order
// memory responses are routed back to the right L1.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   bus          : l2_request_arbiter_if.slave (L1 requests/fills, memory)
//   overflow     : sticky per-port "request dropped, queue full" (bit0 = A)
//   orphan_resp  : sticky "memory response arrived with no read outstanding"
// Parameters:
//   REQ_DEPTH : per-port request queue entries (power of 2, >= 2)
//   MEM_DELAY : memory read latency in cycles (rden to rvalid)
//   TAG_DEPTH : outstanding-read tag entries (power of 2, >= MEM_DELAY+1
//               for full read bandwidth; smaller values throttle reads)
// ---------------------------------------------------------------------------
module l2_request_arbiter
  import l2_arb_pkg::*;
#(
  parameter int REQ_DEPTH = 4,
  parameter int MEM_DELAY = 5,
  parameter int TAG_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  l2_request_arbiter_if.slave     bus,
  output logic [NUM_PORTS-1:0]    overflow,
  output logic                    orphan_resp
);

  // Per-port views of the bus so the port logic can be generated.
  logic [ADDR_W-1:0]    l1_addr  [NUM_PORTS];
  logic [LINE_W-1:0]    l1_wdata [NUM_PORTS];
  logic [NUM_PORTS-1:0] l1_rden;
  logic [NUM_PORTS-1:0] l1_wren;

  assign l1_addr[PORT_A]  = bus.l1_addr_a;
  assign l1_addr[PORT_B]  = bus.l1_addr_b;
  assign l1_wdata[PORT_A] = bus.l1_wdata_a;
  assign l1_wdata[PORT_B] = bus.l1_wdata_b;
  assign l1_rden          = {bus.l1_rden_b, bus.l1_rden_a};
  assign l1_wren          = {bus.l1_wren_b, bus.l1_wren_a};

  req_entry_t           head [NUM_PORTS];
  logic [NUM_PORTS-1:0] q_push;
  logic [NUM_PORTS-1:0] q_pop;
  logic [NUM_PORTS-1:0] q_full;
  logic [NUM_PORTS-1:0] q_empty;
  logic [NUM_PORTS-1:0] wr_pend;
  logic [NUM_PORTS-1:0] rd_pend;
  logic [NUM_PORTS-1:0] elig;

  // A combined rd+wr entry issues its write first; write_done_q remembers
  // that the write half has gone so the same head then issues its read.
  logic [NUM_PORTS-1:0] write_done_q;
  logic [NUM_PORTS-1:0] write_done_d;
  port_id_t             rr_q;       // port preferred when both are eligible
  port_id_t             rr_d;
  logic [NUM_PORTS-1:0] overflow_q;
  logic [NUM_PORTS-1:0] overflow_d;
  logic                 orphan_q;
  logic                 orphan_d;

  logic                 tag_push;
  logic                 tag_pop;
  logic [0:0]           tag_head;
  logic                 tag_full;
  logic                 tag_empty;

  logic                 grant_valid;
  port_id_t             grant_port;
  logic [ADDR_W-1:0]    mem_addr;
  logic [LINE_W-1:0]    mem_wdata;
  logic                 mem_rden;
  logic                 mem_wren;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    req_entry_t       push_entry;
    logic [REQ_W-1:0] head_bits;

    assign q_push[gi] = l1_rden[gi] | l1_wren[gi];
    assign push_entry = '{rd: l1_rden[gi], wr: l1_wren[gi],
                          addr: l1_addr[gi], wdata: l1_wdata[gi]};

    sync_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (REQ_DEPTH)
    ) u_req_q (
      .clk     (clk),
      .reset   (reset),
      .push_i  (q_push[gi]),
      .data_i  (push_entry),
      .pop_i   (q_pop[gi]),
      .data_o  (head_bits),
      .full_o  (q_full[gi]),
      .empty_o (q_empty[gi])
    );

    assign head[gi]    = req_entry_t'(head_bits);
    assign wr_pend[gi] = !q_empty[gi] && head[gi].wr && !write_done_q[gi];
    assign rd_pend[gi] = !q_empty[gi] && head[gi].rd && !wr_pend[gi];
    // A read needs a free tag slot; writes never wait on the tag queue.
    assign elig[gi]    = wr_pend[gi] || (rd_pend[gi] && !tag_full);
  end

  // With a tag queue shallower than the memory pipeline, read issue is
  // throttled by tag_full; no extra logic is needed for that case.
  if (TAG_DEPTH < MEM_DELAY + 1) begin : g_tag_throttles_reads
  end

  always_comb begin
    grant_valid  = 1'b0;
    grant_port   = PORT_A;
    if (elig[PORT_A] && elig[PORT_B]) begin
      grant_valid = 1'b1;
      grant_port  = rr_q;
    end else if (elig[PORT_A]) begin
      grant_valid = 1'b1;
      grant_port  = PORT_A;
    end else if (elig[PORT_B]) begin
      grant_valid = 1'b1;
      grant_port  = PORT_B;
    end

    mem_rden     = 1'b0;
    mem_wren     = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    q_pop        = '0;
    tag_push     = 1'b0;
    write_done_d = write_done_q;
    rr_d         = rr_q;

    if (grant_valid) begin
      rr_d     = (grant_port == PORT_A) ? PORT_B : PORT_A;
      mem_addr = head[grant_port].addr;
      if (wr_pend[grant_port]) begin
        mem_wren  = 1'b1;
        mem_wdata = head[grant_port].wdata;
        if (head[grant_port].rd) write_done_d[grant_port] = 1'b1;
        else                     q_pop[grant_port]        = 1'b1;
      end else begin
        mem_rden                  = 1'b1;
        tag_push                  = 1'b1;
        q_pop[grant_port]         = 1'b1;
        write_done_d[grant_port]  = 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (1),
    .DEPTH (TAG_DEPTH)
  ) u_tag_q (
    .clk     (clk),
    .reset   (reset),
    .push_i  (tag_push),
    .data_i  (grant_port),
    .pop_i   (tag_pop),
    .data_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  assign tag_pop    = bus.mem_rvalid && !tag_empty;
  assign overflow_d = overflow_q | (q_push & q_full);
  assign orphan_d   = orphan_q | (bus.mem_rvalid && tag_empty);

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q         <= PORT_A;
      write_done_q <= '0;
      overflow_q   <= '0;
      orphan_q     <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      write_done_q <= write_done_d;
      overflow_q   <= overflow_d;
      orphan_q     <= orphan_d;
    end
  end

  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.mem_rden    = mem_rden;
  assign bus.mem_wren    = mem_wren;
  assign bus.l1_rdata_a  = bus.mem_rdata;
  assign bus.l1_rdata_b  = bus.mem_rdata;
  assign bus.l1_rvalid_a = tag_pop && (tag_head == PORT_A);
  assign bus.l1_rvalid_b = tag_pop && (tag_head == PORT_B);
  assign overflow        = overflow_q;
  assign orphan_resp     = orphan_q;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l2_request_arbiter
// Two arbiter instances: inst 0 with TAG_DEPTH=8, inst 1 with TAG_DEPTH=2.
// Each has a fixed-latency memory model returning a line derived from the
// read address. Memory ops and L1 fills are logged per cycle and compared
// against hand-computed cycle/port/address expectations.
// ---------------------------------------------------------------------------
module tb_l2_request_arbiter;
  import l2_arb_pkg::*;

  localparam int NI        = 2;
  localparam int MEM_DELAY = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0]  addr_a [NI];
  logic [31:0]  addr_b [NI];
  logic         rden_a [NI];
  logic         rden_b [NI];
  logic         wren_a [NI];
  logic         wren_b [NI];
  logic [127:0] wdata_a [NI];
  logic [127:0] wdata_b [NI];
  logic         inject_rv [NI];

  logic [1:0]   ovf [NI];
  logic         orphan [NI];
  logic         o_rden [NI];
  logic         o_wren [NI];
  logic         o_rva [NI];
  logic         o_rvb [NI];

  typedef struct {
    int           cyc;
    bit           rd;
    bit           wr;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } mem_ev_t;

  typedef struct {
    int           cyc;
    bit           port;
    logic [127:0] data_a;
    logic [127:0] data_b;
  } rv_ev_t;

  mem_ev_t mem_log [NI][$];
  rv_ev_t  rv_log  [NI][$];
  int      outstanding [NI];
  int      max_out [NI];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [127:0] line_of(logic [31:0] a);
    return {a, ~a, a ^ 32'h1234_5678, 32'hC0DE_0000 | {16'h0, a[15:0]}};
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    l2_request_arbiter_if bus ();
    logic        rd_pipe   [MEM_DELAY];
    logic [31:0] addr_pipe [MEM_DELAY];

    assign bus.l1_addr_a  = addr_a[gi];
    assign bus.l1_addr_b  = addr_b[gi];
    assign bus.l1_rden_a  = rden_a[gi];
    assign bus.l1_rden_b  = rden_b[gi];
    assign bus.l1_wren_a  = wren_a[gi];
    assign bus.l1_wren_b  = wren_b[gi];
    assign bus.l1_wdata_a = wdata_a[gi];
    assign bus.l1_wdata_b = wdata_b[gi];
    assign bus.mem_rvalid = rd_pipe[MEM_DELAY-1] | inject_rv[gi];
    assign bus.mem_rdata  = line_of(addr_pipe[MEM_DELAY-1]);

    assign o_rden[gi] = bus.mem_rden;
    assign o_wren[gi] = bus.mem_wren;
    assign o_rva[gi]  = bus.l1_rvalid_a;
    assign o_rvb[gi]  = bus.l1_rvalid_b;

    l2_request_arbiter #(
      .REQ_DEPTH (4),
      .MEM_DELAY (MEM_DELAY),
      .TAG_DEPTH ((gi == 0) ? 8 : 2)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .overflow    (ovf[gi]),
      .orphan_resp (orphan[gi])
    );

    // Fixed-latency memory: rden in cycle T gives rvalid in cycle T+MEM_DELAY.
    always @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < MEM_DELAY; k++) begin
          rd_pipe[k]   <= 1'b0;
          addr_pipe[k] <= '0;
        end
      end else begin
        rd_pipe[0]   <= bus.mem_rden;
        addr_pipe[0] <= bus.mem_addr;
        for (int k = 1; k < MEM_DELAY; k++) begin
          rd_pipe[k]   <= rd_pipe[k-1];
          addr_pipe[k] <= addr_pipe[k-1];
        end
      end
    end

    always @(negedge clk) begin
      if (!reset) begin
        if (bus.mem_rden || bus.mem_wren)
          mem_log[gi].push_back('{cyc, bus.mem_rden, bus.mem_wren, bus.mem_addr, bus.mem_wdata});
        if (bus.l1_rvalid_a)
          rv_log[gi].push_back('{cyc, 1'b0, bus.l1_rdata_a, bus.l1_rdata_b});
        if (bus.l1_rvalid_b)
          rv_log[gi].push_back('{cyc, 1'b1, bus.l1_rdata_a, bus.l1_rdata_b});
        outstanding[gi] = outstanding[gi] + int'(bus.mem_rden) - int'(rd_pipe[MEM_DELAY-1]);
        if (outstanding[gi] > max_out[gi]) max_out[gi] = outstanding[gi];
      end
    end
  end

  task automatic check_eq(string tag, logic [127:0] got, logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NI; i++) begin
      addr_a[i] = '0;  addr_b[i] = '0;
      rden_a[i] = 1'b0; rden_b[i] = 1'b0;
      wren_a[i] = 1'b0; wren_b[i] = 1'b0;
      wdata_a[i] = '0; wdata_b[i] = '0;
      inject_rv[i] = 1'b0;
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < NI; i++) begin
      mem_log[i].delete();
      rv_log[i].delete();
      outstanding[i] = 0;
      max_out[i] = 0;
    end
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic chk_mem(int i, int idx, int t0, int rcyc, bit rd, bit wr,
                         logic [31:0] a, string tag);
    if (idx >= mem_log[i].size()) begin
      check_eq({tag, "_present"}, 128'd0, 128'd1);
    end else begin
      check_eq({tag, "_cyc"},  128'(mem_log[i][idx].cyc - t0), 128'(rcyc));
      check_eq({tag, "_op"},   {126'd0, mem_log[i][idx].rd, mem_log[i][idx].wr}, {126'd0, rd, wr});
      check_eq({tag, "_addr"}, {96'd0, mem_log[i][idx].addr}, {96'd0, a});
    end
  endtask

  task automatic chk_rv(int i, int idx, int t0, int rcyc, bit port,
                        logic [31:0] a, string tag);
    if (idx >= rv_log[i].size()) begin
      check_eq({tag, "_present"}, 128'd0, 128'd1);
    end else begin
      check_eq({tag, "_cyc"},   128'(rv_log[i][idx].cyc - t0), 128'(rcyc));
      check_eq({tag, "_port"},  {127'd0, rv_log[i][idx].port}, {127'd0, port});
      check_eq({tag, "_data_a"}, rv_log[i][idx].data_a, line_of(a));
      check_eq({tag, "_data_b"}, rv_log[i][idx].data_b, line_of(a));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got=%0d exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int a_cnt;
    int w_cnt;
    int rva_cnt;
    logic [31:0] a_addrs [$];
    int          a_cycs  [$];
    logic [31:0] exp_addr [6];

    reset = 1'b1;
    idle_all();
    clear_logs();
    do_reset();

    // Reset state on both instances.
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("rst%0d_rden", i),   {127'd0, o_rden[i]}, 128'd0);
      check_eq($sformatf("rst%0d_wren", i),   {127'd0, o_wren[i]}, 128'd0);
      check_eq($sformatf("rst%0d_rva", i),    {127'd0, o_rva[i]},  128'd0);
      check_eq($sformatf("rst%0d_rvb", i),    {127'd0, o_rvb[i]},  128'd0);
      check_eq($sformatf("rst%0d_ovf", i),    {126'd0, ovf[i]},    128'd0);
      check_eq($sformatf("rst%0d_orphan", i), {127'd0, orphan[i]}, 128'd0);
    end

    // Single read on port A.
    do_reset();
    t0 = cyc;
    rden_a[0] = 1'b1; addr_a[0] = 32'h100;
    step();
    idle_all();
    repeat (12) step();
    check_eq("single_nmem", 128'(mem_log[0].size()), 128'd1);
    chk_mem(0, 0, t0, 1, 1'b1, 1'b0, 32'h100, "single_rd");
    check_eq("single_nrv", 128'(rv_log[0].size()), 128'd1);
    chk_rv(0, 0, t0, 6, 1'b0, 32'h100, "single_rv");
    $display("txn single_read done cycle=%0d", cyc);

    // Simultaneous reads, rr starts at A.
    do_reset();
    t0 = cyc;
    rden_a[0] = 1'b1; addr_a[0] = 32'h40;
    rden_b[0] = 1'b1; addr_b[0] = 32'h80;
    step();
    idle_all();
    repeat (12) step();
    check_eq("simul_nmem", 128'(mem_log[0].size()), 128'd2);
    chk_mem(0, 0, t0, 1, 1'b1, 1'b0, 32'h40, "simul_rd0");
    chk_mem(0, 1, t0, 2, 1'b1, 1'b0, 32'h80, "simul_rd1");
    chk_rv(0, 0, t0, 6, 1'b0, 32'h40, "simul_rv0");
    chk_rv(0, 1, t0, 7, 1'b1, 32'h80, "simul_rv1");
    $display("txn simultaneous_reads done cycle=%0d", cyc);

    // Combined evict + fill on port B.
    do_reset();
    t0 = cyc;
    rden_b[0] = 1'b1; wren_b[0] = 1'b1; addr_b[0] = 32'h200;
    wdata_b[0] = 128'hDEADBEEF;
    step();
    idle_all();
    repeat (12) step();
    check_eq("comb_nmem", 128'(mem_log[0].size()), 128'd2);
    chk_mem(0, 0, t0, 1, 1'b0, 1'b1, 32'h200, "comb_wr");
    if (mem_log[0].size() > 0)
      check_eq("comb_wdata", mem_log[0][0].wdata, 128'hDEADBEEF);
    chk_mem(0, 1, t0, 2, 1'b1, 1'b0, 32'h200, "comb_rd");
    check_eq("comb_nrv", 128'(rv_log[0].size()), 128'd1);
    chk_rv(0, 0, t0, 7, 1'b1, 32'h200, "comb_rv");
    $display("txn evict_fill done cycle=%0d", cyc);

    // Overflow on inst 1: two B reads fill the 2-deep tag queue, then five
    // A reads arrive while B writes keep the memory port busy.
    do_reset();
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      idle_all();
      if (k < 2) begin
        rden_b[1] = 1'b1; addr_b[1] = 32'h2000 + 32'(k * 'h40);
      end else begin
        wren_b[1] = 1'b1; addr_b[1] = 32'h3000 + 32'(k * 'h40);
        wdata_b[1] = 128'(k);
      end
      if (k >= 2 && k <= 6) begin
        rden_a[1] = 1'b1; addr_a[1] = 32'h1000 + 32'((k - 2) * 'h40);
      end
      step();
    end
    idle_all();
    repeat (40) step();
    check_eq("ovf_flag", {126'd0, ovf[1]}, 128'd1);
    a_addrs.delete();
    a_cycs.delete();
    w_cnt = 0;
    foreach (mem_log[1][j]) begin
      if (mem_log[1][j].rd && mem_log[1][j].addr[15:12] == 4'h1) begin
        a_addrs.push_back(mem_log[1][j].addr);
        a_cycs.push_back(mem_log[1][j].cyc - t0);
      end
      if (mem_log[1][j].wr) w_cnt++;
    end
    a_cnt = a_addrs.size();
    check_eq("ovf_a_reads", 128'(a_cnt), 128'd4);
    check_eq("ovf_b_writes", 128'(w_cnt), 128'd8);
    if (a_cnt > 0) check_eq("ovf_first_a_cyc", 128'(a_cycs[0]), 128'd7);
    for (int j = 0; j < 4 && j < a_cnt; j++)
      check_eq($sformatf("ovf_a_addr%0d", j), {96'd0, a_addrs[j]},
               {96'd0, 32'h1000 + 32'(j * 'h40)});
    rva_cnt = 0;
    foreach (rv_log[1][j]) if (rv_log[1][j].port == 1'b0) rva_cnt++;
    check_eq("ovf_a_fills", 128'(rva_cnt), 128'd4);
    $display("txn overflow done cycle=%0d", cyc);

    // Tag backpressure on inst 1: reads on both ports for 3 cycles.
    do_reset();
    t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      idle_all();
      rden_a[1] = 1'b1; addr_a[1] = 32'h1000 + 32'(k * 'h40);
      rden_b[1] = 1'b1; addr_b[1] = 32'h2000 + 32'(k * 'h40);
      step();
    end
    idle_all();
    repeat (30) step();
    exp_addr = '{32'h1000, 32'h2000, 32'h1040, 32'h2040, 32'h1080, 32'h2080};
    check_eq("tag_nmem", 128'(mem_log[1].size()), 128'd6);
    check_eq("tag_max_out", 128'(max_out[1]), 128'd2);
    for (int j = 0; j < 6; j++) begin
      chk_mem(1, j, t0, (j / 2) * 6 + 1 + (j % 2), 1'b1, 1'b0, exp_addr[j],
              $sformatf("tag_rd%0d", j));
      chk_rv(1, j, t0, (j / 2) * 6 + 6 + (j % 2), 1'(j % 2), exp_addr[j],
             $sformatf("tag_rv%0d", j));
    end
    $display("txn tag_backpressure done cycle=%0d", cyc);

    // Orphan response, then reset with requests queued and in flight.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle_all();
      rden_a[0] = 1'b1; addr_a[0] = 32'h500 + 32'(k * 'h40);
      if (k == 0) begin
        inject_rv[0] = 1'b1;
        rden_b[0] = 1'b1; addr_b[0] = 32'h600;
      end
      if (k == 1) begin
        rden_b[0] = 1'b1; wren_b[0] = 1'b1; addr_b[0] = 32'h640;
        wdata_b[0] = 128'h1234;
      end
      @(negedge clk);
      if (k == 0) begin
        check_eq("orphan_rva", {127'd0, o_rva[0]}, 128'd0);
        check_eq("orphan_rvb", {127'd0, o_rvb[0]}, 128'd0);
      end
      if (k == 1) check_eq("orphan_flag", {127'd0, orphan[0]}, 128'd1);
      step();
    end
    idle_all();
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_logs();
    @(negedge clk);
    check_eq("midrst_rden",   {127'd0, o_rden[0]}, 128'd0);
    check_eq("midrst_wren",   {127'd0, o_wren[0]}, 128'd0);
    check_eq("midrst_orphan", {127'd0, orphan[0]}, 128'd0);
    check_eq("midrst_ovf",    {126'd0, ovf[0]},    128'd0);
    repeat (15) step();
    check_eq("midrst_nmem", 128'(mem_log[0].size()), 128'd0);
    check_eq("midrst_nrv",  128'(rv_log[0].size()),  128'd0);
    $display("txn reset_midflight done cycle=%0d", cyc);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
